// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline front end.
package cpu_pkg;

    // Default datapath widths of the pipeline.
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_INST_W = 16;

    // Instruction presented to decode when nothing valid is available.
    localparam logic [CPU_INST_W-1:0] NOP_INST = 16'h0000;

    // Fetch controller states: normal fetching, or waiting out a stale request.
    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } if_state_e;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [CPU_ADDR_W-1:0] pc;
        logic [CPU_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO between the fetch controller and decode.
// Head entry is read straight out of registered storage, so there is no
// combinational path from the push side to the head outputs.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // the pre-edge values of its inputs, independent of statement order.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; written only on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; empty/count
        // guard every read, so stale contents are never observed.
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : fetch_fifo

// File: rtl/if_fetch_unit.sv
// Instruction Fetch stage: owns the PC, issues one imem request at a time,
// buffers fetched {pc,inst} pairs in a prefetch FIFO and presents the head
// to decode. Branch redirects flush the FIFO; a request that is still in
// flight when the redirect arrives is completed and its data discarded.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INST_W   = CPU_INST_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o
);

    localparam int ENTRY_W = ADDR_W + INST_W;

    if_state_e         state;
    if_state_e         state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] target_pc;
    logic [ADDR_W-1:0] target_pc_n;

    logic               req_raw;
    logic               ack_take;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_pc;
    logic [INST_W-1:0]  head_inst;

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({fetch_pc, imem_rdata_i}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_pc   = fifo_head[ENTRY_W-1:INST_W];
    assign head_inst = fifo_head[INST_W-1:0];

    // The address is always the PC of the request in flight; in S_DROP
    // fetch_pc still holds the abandoned address, keeping addr stable.
    assign imem_req_o  = req_raw && !rst;
    assign imem_addr_o = fetch_pc;
    assign ack_take    = req_raw && imem_ack_i;

    // Decode-facing outputs come only from FIFO storage, forced idle in reset.
    assign if_valid_o = !rst && !fifo_empty;
    assign if_pc_o    = if_valid_o ? head_pc   : '0;
    assign if_inst_o  = if_valid_o ? head_inst : INST_W'(NOP_INST);

    // A redirect flushes the presented entry, so it is never consumed.
    assign fifo_pop = if_valid_o && !stall_i && !redirect_i;

    // Fetch controller state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            target_pc <= target_pc_n;
        end
    end

    // Next-state, PC update and request/push/flush decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        target_pc_n = target_pc;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        req_raw     = 1'b0;

        // Request gating: in S_FETCH only while there is room for the reply,
        // in S_DROP always, so an abandoned request is still seen through.
        unique case (state)
            S_FETCH: req_raw = !fifo_full;
            S_DROP:  req_raw = 1'b1;
            default: req_raw = 1'b0;
        endcase

        if (redirect_i) begin
            fifo_flush = 1'b1;
            if (!req_raw || imem_ack_i) begin
                // Nothing left in flight: refetch from the new target now.
                state_n    = S_FETCH;
                fetch_pc_n = redirect_pc_i;
            end else begin
                // Current request still pending: finish it, then refetch.
                state_n     = S_DROP;
                target_pc_n = redirect_pc_i;
            end
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (ack_take) begin
                        fifo_push  = 1'b1;
                        fetch_pc_n = fetch_pc + ADDR_W'(1);
                    end
                end
                S_DROP: begin
                    if (ack_take) begin
                        state_n    = S_FETCH;
                        fetch_pc_n = target_pc;
                    end
                end
                default: state_n = S_FETCH;
            endcase
        end
    end

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a memory model with programmable ack
// latency (mem[a] = 16'h1000 + a), a scoreboard of expected {pc,inst} pairs
// consumed whenever decode accepts an instruction, plus cycle-exact checks
// of the imem handshake, stall, redirect, wrap and reset behaviour.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic        if_valid_o;
    logic [15:0] if_pc_o;
    logic [15:0] if_inst_o;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int wait_cnt = 0;
    int acks;

    fetch_entry_t exp_q[$];

    if_fetch_unit #(
        .ADDR_W   (16),
        .INST_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    always #5 clk = ~clk;

    // Memory model: ack after lat cycles of a held request (lat=1 -> ack=req).
    assign imem_ack_i   = imem_req_o && (wait_cnt >= lat - 1);
    assign imem_rdata_i = 16'h1000 + imem_addr_o;

    always @(posedge clk) begin
        if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = 16'h1000 + pc;
        exp_q.push_back(e);
    endtask

    // Start of the next cycle: inputs change just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sampling point, after the scoreboard process has acted at the falling edge.
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard consumer: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (!rst && if_valid_o && !stall_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr_pc", {16'h0, if_pc_o}, 32'hFFFF_FFFF);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("sb_pc", {16'h0, if_pc_o}, {16'h0, e.pc});
                check("sb_inst", {16'h0, if_inst_o}, {16'h0, e.inst});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 16'h0000;
        lat           = 1;

        // ---- 1: reset and zero-wait streaming ----
        next_cycle();
        mid();
        check("rst_req", imem_req_o, 0);
        check("rst_valid", if_valid_o, 0);
        check("rst_pc", if_pc_o, 0);
        check("rst_inst", if_inst_o, NOP_INST);
        next_cycle();
        for (int i = 0; i < 6; i++) push_exp(16'(i));
        rst = 1'b0;                                   // cycle 1
        mid();
        check("c1_req", imem_req_o, 1);
        check("c1_addr", imem_addr_o, 16'h0000);
        check("c1_valid", if_valid_o, 0);
        next_cycle();                                 // cycle 2
        mid();
        check("c2_valid", if_valid_o, 1);
        next_cycle();
        next_cycle();
        next_cycle();                                 // cycle 5

        // ---- 2: stall while pc=3 is presented ----
        stall_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall_pc", if_pc_o, 16'h0003);
            check("stall_inst", if_inst_o, 16'h1003);
            check("stall_valid", if_valid_o, 1);
            if (imem_req_o && imem_ack_i) acks++;
            if (i < 4) next_cycle();
        end
        check("stall_acks_le_depth", (acks <= 2), 1);
        check("stall_req_dropped", imem_req_o, 0);
        next_cycle();                                 // cycle 10
        stall_i = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();                                 // cycle 13
        stall_i = 1'b1;
        mid();
        check("stall_release_drained", exp_q.size(), 0);

        // ---- 3: three-cycle memory latency ----
        next_cycle();
        next_cycle();                                 // cycle 15, FIFO full
        lat           = 3;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0005;
        mid();
        check("c15_req_idle", imem_req_o, 0);
        next_cycle();                                 // cycle 16
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        push_exp(16'h0005);
        push_exp(16'h0006);
        mid();
        check("lat_flushed", if_valid_o, 0);
        check("lat_req_c16", imem_req_o, 1);
        check("lat_addr_c16", imem_addr_o, 16'h0005);
        next_cycle();
        mid();
        check("lat_addr_c17", imem_addr_o, 16'h0005);
        check("lat_ack_c17", imem_ack_i, 0);
        next_cycle();
        mid();
        check("lat_addr_c18", imem_addr_o, 16'h0005);
        check("lat_ack_c18", imem_ack_i, 1);
        next_cycle();
        mid();
        check("lat_valid_c19", if_valid_o, 1);
        check("lat_addr_c19", imem_addr_o, 16'h0006);
        next_cycle();
        mid();
        check("lat_valid_c20", if_valid_o, 0);
        next_cycle();
        mid();
        check("lat_valid_c21", if_valid_o, 0);
        next_cycle();                                 // cycle 22
        mid();
        check("lat_valid_c22", if_valid_o, 1);
        check("lat_addr_c22", imem_addr_o, 16'h0007);

        // ---- 4: redirect while request to 7 is un-acked ----
        next_cycle();                                 // cycle 23
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0040;
        push_exp(16'h0040);
        mid();
        check("drop_req_c23", imem_req_o, 1);
        check("drop_ack_c23", imem_ack_i, 0);
        next_cycle();                                 // cycle 24
        redirect_i = 1'b0;
        mid();
        check("drop_addr_held", imem_addr_o, 16'h0007);
        check("drop_req_held", imem_req_o, 1);
        check("drop_valid", if_valid_o, 0);
        next_cycle();                                 // cycle 25
        mid();
        check("drop_new_addr", imem_addr_o, 16'h0040);
        check("drop_valid_c25", if_valid_o, 0);
        next_cycle();
        next_cycle();
        next_cycle();                                 // cycle 28
        mid();
        check("drop_first_valid", if_valid_o, 1);
        check("drop_first_pc", if_pc_o, 16'h0040);
        next_cycle();
        next_cycle();                                 // cycle 30

        // ---- 5: redirect together with ack and stall ----
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0080;
        stall_i       = 1'b1;
        mid();
        check("rda_ack_c30", imem_ack_i, 1);
        check("rda_addr_c30", imem_addr_o, 16'h0041);
        next_cycle();                                 // cycle 31
        redirect_i = 1'b0;
        lat        = 1;
        mid();
        check("rda_flushed", if_valid_o, 0);
        check("rda_req", imem_req_o, 1);
        check("rda_addr", imem_addr_o, 16'h0080);
        next_cycle();
        mid();
        check("rda_head_pc", if_pc_o, 16'h0080);
        check("rda_head_inst", if_inst_o, 16'h1080);
        next_cycle();                                 // cycle 33
        mid();
        check("rda_full_req", imem_req_o, 0);
        check("rda_head_stable", if_pc_o, 16'h0080);

        // ---- 6: PC wrap, then reset mid-wait ----
        next_cycle();                                 // cycle 34
        redirect_i    = 1'b1;
        redirect_pc_i = 16'hFFFE;
        next_cycle();                                 // cycle 35
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        push_exp(16'hFFFE);
        push_exp(16'hFFFF);
        push_exp(16'h0000);
        mid();
        check("wrap_addr_fffe", imem_addr_o, 16'hFFFE);
        next_cycle();
        mid();
        check("wrap_addr_ffff", imem_addr_o, 16'hFFFF);
        next_cycle();
        mid();
        check("wrap_addr_0000", imem_addr_o, 16'h0000);
        next_cycle();                                 // cycle 38
        stall_i = 1'b1;
        lat     = 3;
        mid();
        check("wrap_head_pc", if_pc_o, 16'h0000);
        check("wrap_pending", imem_ack_i, 0);
        next_cycle();                                 // cycle 39
        rst = 1'b1;
        exp_q.delete();
        mid();
        check("midrst_req", imem_req_o, 0);
        check("midrst_valid", if_valid_o, 0);
        check("midrst_inst", if_inst_o, NOP_INST);
        next_cycle();                                 // cycle 40
        rst     = 1'b0;
        stall_i = 1'b0;
        push_exp(16'h0000);
        mid();
        check("restart_req", imem_req_o, 1);
        check("restart_addr", imem_addr_o, 16'h0000);
        check("restart_valid", if_valid_o, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            next_cycle();
            mid();
        end
        check("final_queue_drained", exp_q.size(), 0);
        stall_i = 1'b1;
        next_cycle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_fetch_unit
